game_flow_ctrl: RTL and testbench
=================================

GAME_FLOW_CTRL -- requirements
Module: game_flow_ctrl

Interface
REQ-001 SHALL have parameter LEVELS_PER_WORLD, default 4, number of levels per world (2..8).
REQ-002 SHALL have parameter NUM_WORLDS, default 4, number of worlds (2..4).
REQ-003 SHALL have parameter START_LIVES, default 3, lives loaded at game start (1..MAX_LIVES).
REQ-004 SHALL have parameter MAX_LIVES, default 9, lives saturation value (<=15).
REQ-005 SHALL have parameter BANNER_FRAMES, default 120, frame_tick count spent in each banner state (>=1).
REQ-006 SHALL have port clk, input, 1, system clock; the block's only clock.
REQ-007 SHALL have port rst, input, 1, reset; asynchronous and active-high.
REQ-008 SHALL have port start_btn, input, 1, raw asynchronous start/pause button.
REQ-009 SHALL have port frame_tick, input, 1, one-cycle pulse per video frame.
REQ-010 SHALL have port level_complete, input, 1, one-cycle pulse: player reached destination.
REQ-011 SHALL have port player_hit, input, 1, one-cycle pulse: player touched an obstacle.
REQ-012 SHALL have port gameStatus, output, 3, current state code.
REQ-013 SHALL have port world, output, 2, current world index.
REQ-014 SHALL have port level, output, 3, current level index within world.
REQ-015 SHALL have port lives, output, 4, remaining lives.
REQ-016 SHALL have port play_en, output, 1, high only in PLAYING; gates object motion.
REQ-017 SHALL have port obj_reset, output, 1, one-cycle pulse to re-initialise scrolls/obstacles/player.

Function
REQ-018 SHALL synchronise start_btn through two flops and act only on the rising edge of the synchronised signal (start_edge).
REQ-019 SHALL implement states, with gameStatus codes: START=0, PLAYING=1, LEVEL_INC=2, WORLD_INC=3, LIFE_LOST=4, LOSE=5, WIN=6, PAUSED=7.
REQ-020 SHALL hold world=0, level=0, lives=START_LIVES while in START; start_edge -> PLAYING.
REQ-021 SHALL, in PLAYING, on level_complete with level<LEVELS_PER_WORLD-1: increment level, enter LEVEL_INC.
REQ-022 SHALL, in PLAYING, on level_complete with last level and world<NUM_WORLDS-1: increment world, clear level to 0, increment lives saturating at MAX_LIVES, enter WORLD_INC.
REQ-023 SHALL, in PLAYING, on level_complete with last level of last world: enter WIN; world/level/lives unchanged.
REQ-024 SHALL, in PLAYING, on player_hit with lives>1: decrement lives, enter LIFE_LOST; with lives==1: set lives=0, enter LOSE.
REQ-025 SHALL give level_complete priority over player_hit when both pulse in the same cycle.
REQ-026 SHALL, in PLAYING, on start_edge with no level_complete/player_hit that cycle: enter PAUSED; in PAUSED, start_edge -> PLAYING.
REQ-027 SHALL update world/level/lives on the same clock edge as the state transition (registered, no extra latency).
REQ-028 SHALL, in LEVEL_INC/WORLD_INC/LIFE_LOST, clear a frame counter on entry, count frame_tick pulses, and return to PLAYING on the edge of the BANNER_FRAMES-th frame_tick.
REQ-029 SHALL ignore start_btn, level_complete and player_hit in banner states, and level_complete/player_hit in START, PAUSED, LOSE, WIN.
REQ-030 SHALL, in LOSE or WIN, on start_edge enter START (counters reload to REQ-020 values on that edge).
REQ-031 SHALL assert obj_reset for exactly the first cycle of PLAYING when entered from START, LEVEL_INC, WORLD_INC or LIFE_LOST; never when entered from PAUSED.
REQ-032 SHALL drive play_en combinationally equal to (state==PLAYING).

Reset
REQ-033 SHALL on rst=1, asynchronously: state=START, gameStatus=0, world=0, level=0, lives=START_LIVES, play_en=0, obj_reset=0, frame counter=0, sync/edge flops=0.
REQ-034 SHALL, on reset mid-banner or mid-game, discard all progress; first start_edge after release behaves per REQ-020.

Verification
REQ-035 SHALL cover: reset, press start -> gameStatus 0->1, obj_reset high one cycle, lives=3, level=0.
REQ-036 SHALL cover: level_complete at level 3, world 0, lives 3 -> WORLD_INC (3), world=1, level=0, lives=4; after 120 frame_ticks -> PLAYING with obj_reset pulse.
REQ-037 SHALL cover: lives=1, level_complete and player_hit same cycle at level 1 -> LEVEL_INC, level=2, lives stays 1.
REQ-038 SHALL cover: player_hit with lives=1 -> LOSE (5), lives=0, play_en=0; start press -> START, lives=3.
REQ-039 SHALL cover: start press in PLAYING -> PAUSED (7), play_en=0; frame_ticks and hits ignored; press again -> PLAYING, no obj_reset.
REQ-040 SHALL cover: lives=9 then world advance -> lives stays 9; last level of world 3 -> WIN (6).

Source files
------------

// File: rtl/game_flow_ctrl.sv
// Game flow sequencer: start/play/pause, level and world progression, lives, and
// frame-timed banner states between rounds.
module game_flow_ctrl #(
  parameter int LEVELS_PER_WORLD = 4,
  parameter int NUM_WORLDS       = 4,
  parameter int START_LIVES      = 3,
  parameter int MAX_LIVES        = 9,
  parameter int BANNER_FRAMES    = 120
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_btn,
  input  logic       frame_tick,
  input  logic       level_complete,
  input  logic       player_hit,
  output logic [2:0] gameStatus,
  output logic [1:0] world,
  output logic [2:0] level,
  output logic [3:0] lives,
  output logic       play_en,
  output logic       obj_reset
);

  // state | meaning: START idle | PLAYING live | LEVEL_INC/WORLD_INC/LIFE_LOST banners
  //                  LOSE/WIN game over | PAUSED frozen, resumes without obj_reset
  typedef enum logic [2:0] {
    ST_START     = 3'd0,
    ST_PLAYING   = 3'd1,
    ST_LEVEL_INC = 3'd2,
    ST_WORLD_INC = 3'd3,
    ST_LIFE_LOST = 3'd4,
    ST_LOSE      = 3'd5,
    ST_WIN       = 3'd6,
    ST_PAUSED    = 3'd7
  } state_t;

  localparam int         FW          = $clog2(BANNER_FRAMES + 1);
  localparam logic [2:0] LAST_LEVEL  = 3'(LEVELS_PER_WORLD - 1);
  localparam logic [1:0] LAST_WORLD  = 2'(NUM_WORLDS - 1);
  localparam logic [3:0] LIVES_INIT  = 4'(START_LIVES);
  localparam logic [3:0] LIVES_MAX   = 4'(MAX_LIVES);
  localparam logic [FW-1:0] FRAME_TC = FW'(BANNER_FRAMES - 1);

  logic          r_sync1, r_sync2, r_sync_d;
  logic          w_start_edge;
  state_t        r_state, w_state_nxt;
  logic [1:0]    r_world, w_world_nxt;
  logic [2:0]    r_level, w_level_nxt;
  logic [3:0]    r_lives, w_lives_nxt;
  logic [FW-1:0] r_frame_cnt, w_frame_nxt;
  logic          r_obj_reset, w_obj_reset_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_sync_d <= 1'b0;
    end else begin
      r_sync1  <= start_btn;
      r_sync2  <= r_sync1;
      r_sync_d <= r_sync2;
    end
  end

  assign w_start_edge = r_sync2 & ~r_sync_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_START;
      r_world     <= 2'd0;
      r_level     <= 3'd0;
      r_lives     <= LIVES_INIT;
      r_frame_cnt <= '0;
      r_obj_reset <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_world     <= w_world_nxt;
      r_level     <= w_level_nxt;
      r_lives     <= w_lives_nxt;
      r_frame_cnt <= w_frame_nxt;
      r_obj_reset <= w_obj_reset_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_world_nxt     = r_world;
    w_level_nxt     = r_level;
    w_lives_nxt     = r_lives;
    w_frame_nxt     = '0;
    w_obj_reset_nxt = 1'b0;
    case (r_state)
      ST_START: begin
        w_world_nxt = 2'd0;
        w_level_nxt = 3'd0;
        w_lives_nxt = LIVES_INIT;
        if (w_start_edge) w_state_nxt = ST_PLAYING;
      end
      ST_PLAYING: begin
        // level_complete outranks player_hit, both outrank pause
        if (level_complete) begin
          if (r_level < LAST_LEVEL) begin
            w_level_nxt = r_level + 3'd1;
            w_state_nxt = ST_LEVEL_INC;
          end else if (r_world < LAST_WORLD) begin
            w_world_nxt = r_world + 2'd1;
            w_level_nxt = 3'd0;
            w_lives_nxt = (r_lives < LIVES_MAX) ? r_lives + 4'd1 : r_lives;
            w_state_nxt = ST_WORLD_INC;
          end else begin
            w_state_nxt = ST_WIN;
          end
        end else if (player_hit) begin
          if (r_lives > 4'd1) begin
            w_lives_nxt = r_lives - 4'd1;
            w_state_nxt = ST_LIFE_LOST;
          end else begin
            w_lives_nxt = 4'd0;
            w_state_nxt = ST_LOSE;
          end
        end else if (w_start_edge) begin
          w_state_nxt = ST_PAUSED;
        end
      end
      ST_LEVEL_INC, ST_WORLD_INC, ST_LIFE_LOST: begin
        w_frame_nxt = r_frame_cnt;
        if (frame_tick) begin
          if (r_frame_cnt == FRAME_TC) begin
            w_frame_nxt = '0;
            w_state_nxt = ST_PLAYING;
          end else begin
            w_frame_nxt = r_frame_cnt + FW'(1);
          end
        end
      end
      ST_LOSE, ST_WIN: begin
        if (w_start_edge) begin
          w_state_nxt = ST_START;
          w_world_nxt = 2'd0;
          w_level_nxt = 3'd0;
          w_lives_nxt = LIVES_INIT;
        end
      end
      ST_PAUSED: begin
        if (w_start_edge) w_state_nxt = ST_PLAYING;
      end
      default: w_state_nxt = ST_START;
    endcase
    w_obj_reset_nxt = (w_state_nxt == ST_PLAYING) && (r_state != ST_PLAYING) &&
                      (r_state != ST_PAUSED);
  end

  assign gameStatus = r_state;
  assign world      = r_world;
  assign level      = r_level;
  assign lives      = r_lives;
  assign play_en    = (r_state == ST_PLAYING);
  assign obj_reset  = r_obj_reset;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Bench for game_flow_ctrl: directed vector table, hand-written banner/pause/win
// sequences, then random play against a behavioural model.
module tb_game_flow_ctrl;

  logic       clk = 1'b0;
  logic       rst, start_btn, frame_tick, level_complete, player_hit;
  logic [2:0] gameStatus, s_gameStatus;
  logic [1:0] world, s_world;
  logic [2:0] level, s_level;
  logic [3:0] lives, s_lives;
  logic       play_en, s_play_en, obj_reset, s_obj_reset;
  logic [13:0] m_out, s_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  game_flow_ctrl u_dut (
    .clk(clk), .rst(rst), .start_btn(start_btn), .frame_tick(frame_tick),
    .level_complete(level_complete), .player_hit(player_hit),
    .gameStatus(gameStatus), .world(world), .level(level), .lives(lives),
    .play_en(play_en), .obj_reset(obj_reset)
  );

  game_flow_ctrl #(.LEVELS_PER_WORLD(2), .NUM_WORLDS(4), .START_LIVES(9),
                   .MAX_LIVES(9), .BANNER_FRAMES(3)) u_dut_sat (
    .clk(clk), .rst(rst), .start_btn(start_btn), .frame_tick(frame_tick),
    .level_complete(level_complete), .player_hit(player_hit),
    .gameStatus(s_gameStatus), .world(s_world), .level(s_level), .lives(s_lives),
    .play_en(s_play_en), .obj_reset(s_obj_reset)
  );

  assign m_out = {gameStatus, world, level, lives, play_en, obj_reset};
  assign s_out = {s_gameStatus, s_world, s_level, s_lives, s_play_en, s_obj_reset};

  typedef struct packed {
    logic       btn, tick, lc, hit;
    logic [2:0] st;
    logic [1:0] w;
    logic [2:0] l;
    logic [3:0] lv;
    logic       p, o;
  } vec_t;

  vec_t vecs [0:10];

  task automatic chk(input string name, input logic [13:0] got, input logic [2:0] st,
                     input logic [1:0] w, input logic [2:0] l, input logic [3:0] lv,
                     input logic p, input logic o);
    logic [13:0] exp_v;
    exp_v = {st, w, l, lv, p, o};
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL %s: got st=%0d w=%0d l=%0d lives=%0d play=%0b objr=%0b, expected st=%0d w=%0d l=%0d lives=%0d play=%0b objr=%0b",
               name, got[13:11], got[10:9], got[8:6], got[5:2], got[1], got[0],
               st, w, l, lv, p, o);
    end
  endtask

  task automatic send(input logic b, input logic t, input logic c, input logic h);
    start_btn = b; frame_tick = t; level_complete = c; player_hit = h;
    @(negedge clk);
  endtask

  task automatic banner(input int n);
    repeat (n) send(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic press();
    repeat (3) send(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic release_btn();
    repeat (3) send(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    send(1'b0, 1'b0, 1'b0, 1'b0);
    send(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  // behavioural model: game rules with a banner countdown
  int   md_mode, md_w, md_l, md_lives, md_left;
  logic md_s1, md_s2, md_sd, md_objr;

  task automatic model_step(input logic r, input logic b, input logic t,
                            input logic c, input logic h);
    int   prev;
    logic edge_seen;
    if (r) begin
      md_mode = 0; md_w = 0; md_l = 0; md_lives = 3; md_left = 0;
      md_s1 = 0; md_s2 = 0; md_sd = 0; md_objr = 0;
      return;
    end
    edge_seen = md_s2 & ~md_sd;
    md_sd = md_s2; md_s2 = md_s1; md_s1 = b;
    prev = md_mode;
    case (md_mode)
      0: begin
        md_w = 0; md_l = 0; md_lives = 3;
        if (edge_seen) md_mode = 1;
      end
      1: begin
        if (c) begin
          if (md_l < 3) begin md_l++; md_mode = 2; end
          else if (md_w < 3) begin
            md_w++; md_l = 0; md_lives = (md_lives + 1 > 9) ? 9 : md_lives + 1; md_mode = 3;
          end else md_mode = 6;
        end else if (h) begin
          if (md_lives > 1) begin md_lives--; md_mode = 4; end
          else begin md_lives = 0; md_mode = 5; end
        end else if (edge_seen) md_mode = 7;
      end
      2, 3, 4: if (t) begin
        md_left--;
        if (md_left == 0) md_mode = 1;
      end
      7: if (edge_seen) md_mode = 1;
      default: if (edge_seen) begin
        md_mode = 0; md_w = 0; md_l = 0; md_lives = 3;
      end
    endcase
    if (md_mode >= 2 && md_mode <= 4 && prev != md_mode) md_left = 120;
    md_objr = (md_mode == 1) && (prev != 1) && (prev != 7);
  endtask

  initial begin
    logic [3:0] lv;
    logic       b, t, c, h, r;
    rst = 1'b1; start_btn = 0; frame_tick = 0; level_complete = 0; player_hit = 0;

    //            btn tick lc hit st w l lv p o
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 3'd0, 4'd3, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 3'd0, 4'd3, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 2'd0, 3'd0, 4'd3, 1'b1, 1'b1};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 2'd0, 3'd0, 4'd3, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 3'd2, 2'd0, 3'd1, 4'd3, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 2'd0, 3'd1, 4'd3, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 2'd0, 3'd1, 4'd3, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 2'd0, 3'd1, 4'd3, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 3'd2, 2'd0, 3'd1, 4'd3, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 2'd0, 3'd1, 4'd3, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 2'd0, 3'd1, 4'd3, 1'b0, 1'b0};

    repeat (2) @(negedge clk);
    chk("reset", m_out, 3'd0, 2'd0, 3'd0, 4'd3, 1'b0, 1'b0);
    rst = 1'b0;

    for (int i = 0; i <= 10; i++) begin
      send(vecs[i].btn, vecs[i].tick, vecs[i].lc, vecs[i].hit);
      chk($sformatf("vec%0d", i), m_out, vecs[i].st, vecs[i].w, vecs[i].l,
          vecs[i].lv, vecs[i].p, vecs[i].o);
    end

    banner(118);
    chk("banner_hold", m_out, 3'd2, 2'd0, 3'd1, 4'd3, 1'b0, 1'b0);
    banner(1);
    chk("banner_exit", m_out, 3'd1, 2'd0, 3'd1, 4'd3, 1'b1, 1'b1);
    send(0, 0, 0, 0);
    chk("objr_once", m_out, 3'd1, 2'd0, 3'd1, 4'd3, 1'b1, 1'b0);

    send(0, 0, 0, 1);
    chk("hit_3to2", m_out, 3'd4, 2'd0, 3'd1, 4'd2, 1'b0, 1'b0);
    banner(120);
    chk("lifelost_exit", m_out, 3'd1, 2'd0, 3'd1, 4'd2, 1'b1, 1'b1);
    send(0, 0, 0, 1);
    chk("hit_2to1", m_out, 3'd4, 2'd0, 3'd1, 4'd1, 1'b0, 1'b0);
    banner(120);
    send(0, 0, 1, 1);
    chk("lc_hit_prio", m_out, 3'd2, 2'd0, 3'd2, 4'd1, 1'b0, 1'b0);
    banner(120);
    chk("lvl_exit", m_out, 3'd1, 2'd0, 3'd2, 4'd1, 1'b1, 1'b1);
    send(0, 0, 0, 1);
    chk("hit_lose", m_out, 3'd5, 2'd0, 3'd2, 4'd0, 1'b0, 1'b0);
    send(0, 1, 1, 1);
    chk("lose_ignore", m_out, 3'd5, 2'd0, 3'd2, 4'd0, 1'b0, 1'b0);
    press();
    chk("lose_to_start", m_out, 3'd0, 2'd0, 3'd0, 4'd3, 1'b0, 1'b0);
    release_btn();
    press();
    chk("start_play", m_out, 3'd1, 2'd0, 3'd0, 4'd3, 1'b1, 1'b1);
    release_btn();
    chk("play_settle", m_out, 3'd1, 2'd0, 3'd0, 4'd3, 1'b1, 1'b0);

    for (int k = 0; k < 3; k++) begin
      send(0, 0, 1, 0);
      chk("lvl_step", m_out, 3'd2, 2'd0, 3'(k + 1), 4'd3, 1'b0, 1'b0);
      banner(120);
    end
    send(0, 0, 1, 0);
    chk("world_inc", m_out, 3'd3, 2'd1, 3'd0, 4'd4, 1'b0, 1'b0);
    banner(119);
    chk("world_hold", m_out, 3'd3, 2'd1, 3'd0, 4'd4, 1'b0, 1'b0);
    banner(1);
    chk("world_exit", m_out, 3'd1, 2'd1, 3'd0, 4'd4, 1'b1, 1'b1);

    press();
    chk("pause", m_out, 3'd7, 2'd1, 3'd0, 4'd4, 1'b0, 1'b0);
    repeat (3) send(0, 1, 1, 1);
    chk("pause_ignore", m_out, 3'd7, 2'd1, 3'd0, 4'd4, 1'b0, 1'b0);
    press();
    chk("unpause", m_out, 3'd1, 2'd1, 3'd0, 4'd4, 1'b1, 1'b0);
    release_btn();
    chk("unpause_settle", m_out, 3'd1, 2'd1, 3'd0, 4'd4, 1'b1, 1'b0);

    lv = 4'd4;
    for (int wi = 1; wi < 4; wi++) begin
      for (int li = 0; li < 4; li++) begin
        send(0, 0, 1, 0);
        if (li < 3) begin
          chk("lvl_adv", m_out, 3'd2, 2'(wi), 3'(li + 1), lv, 1'b0, 1'b0);
          banner(120);
        end else if (wi < 3) begin
          lv = lv + 4'd1;
          chk("world_adv", m_out, 3'd3, 2'(wi + 1), 3'd0, lv, 1'b0, 1'b0);
          banner(120);
        end else begin
          chk("win", m_out, 3'd6, 2'd3, 3'd3, lv, 1'b0, 1'b0);
        end
      end
    end
    send(0, 1, 1, 1);
    chk("win_ignore", m_out, 3'd6, 2'd3, 3'd3, 4'd6, 1'b0, 1'b0);
    press();
    chk("win_to_start", m_out, 3'd0, 2'd0, 3'd0, 4'd3, 1'b0, 1'b0);
    release_btn();

    do_reset();
    chk("sat_reset", s_out, 3'd0, 2'd0, 3'd0, 4'd9, 1'b0, 1'b0);
    press();
    chk("sat_play", s_out, 3'd1, 2'd0, 3'd0, 4'd9, 1'b1, 1'b1);
    release_btn();
    send(0, 0, 1, 0);
    chk("sat_lvl", s_out, 3'd2, 2'd0, 3'd1, 4'd9, 1'b0, 1'b0);
    banner(3);
    chk("sat_banner", s_out, 3'd1, 2'd0, 3'd1, 4'd9, 1'b1, 1'b1);
    send(0, 0, 1, 0);
    chk("lives_sat", s_out, 3'd3, 2'd1, 3'd0, 4'd9, 1'b0, 1'b0);

    // random play including mid-game resets
    rst = 1'b1;
    model_step(1'b1, 0, 0, 0, 0);
    send(0, 0, 0, 0);
    b = 1'b0;
    for (int cyc = 0; cyc < 15000; cyc++) begin
      r = ($urandom_range(0, 2999) == 0);
      if ($urandom_range(0, 39) == 0) b = ~b;
      t = ($urandom_range(0, 1) == 1);
      c = ($urandom_range(0, 24) == 0);
      h = ($urandom_range(0, 39) == 0);
      rst = r;
      model_step(r, b, t, c, h);
      send(b, t, c, h);
      chk("random", m_out, 3'(md_mode), 2'(md_w), 3'(md_l), 4'(md_lives),
          md_mode == 1, md_objr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
